imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_pkg.sv | 18 +
 rtl/imm_decode.sv | 54 +++++
 rtl/imm_extend_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared types and widths for the immediate-extension pipeline.
package imm_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned SRC_WIDTH   = 3;

  typedef enum logic [SRC_WIDTH-1:0] {
    IMM_I     = 3'b000,
    IMM_S     = 3'b001,
    IMM_B     = 3'b010,
    IMM_U     = 3'b011,
    IMM_J     = 3'b100,
    IMM_SHAMT = 3'b101,
    IMM_CSR   = 3'b110,
    IMM_BAD   = 3'b111
  } imm_src_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decode and extension to DATA_WIDTH bits.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [INSTR_WIDTH-1:0] instr,
  input  imm_src_t               imm_src,
  output logic [DATA_WIDTH-1:0]  imm,
  output logic                   err
);

  logic [31:0] field;
  logic        sext;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  // field holds the 32-bit form; sext says whether bit 31 carries into wider outputs.
  always_comb begin
    field = '0;
    sext  = 1'b0;
    err   = 1'b0;
    unique case (imm_src)
      IMM_I: begin
        field = {{20{instr[31]}}, instr[31:20]};
        sext  = 1'b1;
      end
      IMM_S: begin
        field = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        sext  = 1'b1;
      end
      IMM_B: begin
        field = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        sext  = 1'b1;
      end
      IMM_U: begin
        field = {instr[31:12], 12'b0};
        sext  = 1'b1;
      end
      IMM_J: begin
        field = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        sext  = 1'b1;
      end
      IMM_SHAMT: field = (DATA_WIDTH == 64) ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
      IMM_CSR:   field = {27'b0, instr[19:15]};
      IMM_BAD:   err   = 1'b1;
      default:   ;
    endcase
  end

  assign imm = sext ? DATA_WIDTH'($signed(field)) : DATA_WIDTH'(field);

endmodule

// File: rtl/imm_extend_pipe.sv
// Immediate decode feeding a DEPTH-entry valid/ready output queue (1-cycle latency).
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INSTR_WIDTH-1:0]       Instr,
  input  logic [SRC_WIDTH-1:0]         ImmSrc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        ImmOp,
  output logic                         ImmErr,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_imm [DEPTH];
  logic [DEPTH-1:0]      mem_err;
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_err;
  logic                  push, pop;

  imm_decode #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_decode (
    .instr  (Instr),
    .imm_src(imm_src_t'(ImmSrc)),
    .imm    (dec_imm),
    .err    (dec_err)
  );

  // Explicit wrap so non-power-of-two depths stay in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;
  assign ImmOp     = out_valid ? mem_imm[rd_q] : '0;
  assign ImmErr    = out_valid ? mem_err[rd_q] : 1'b0;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is unreset; the empty-queue gating keeps stale data off the outputs.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_imm[wr_q] <= dec_imm;
      mem_err[wr_q] <= dec_err;
    end
  end

endmodule
